neuron_requant_pack: RTL and testbench

//  Downstream of the 4-lane MAC accumulator: takes each finished 26-bit neuron sum (acc_valid = accumulator done pulse),

---
 rtl/neuron_requant_pack.sv | 217 +++++++++++++++++++++
 tb/tb_neuron_requant_pack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_requant_pack.sv
// rtl/neuron_requant_pack.sv - requantize neuron sums to int8, pack 4 per word, track argmax
module neuron_requant_pack #(
  parameter int ACC_W  = 26,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_neurons,
  input  logic [4:0]        shift,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              layer_done,
  output logic [CNT_W-1:0]  max_idx,
  output logic [7:0]        max_val,
  output logic              overrun_err
);

  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] Q_MAX = SW'(127);
  localparam logic signed [SW-1:0] Q_MIN = SW'(-128);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_q, cnt_q, cnt_d;
  logic [4:0]          shift_q;
  logic                relu_q;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                overrun_q, overrun_d;
  logic                start_ok, accept, last_d;

  // S1 stage: rounded, shifted sum plus its neuron index
  logic                s1_v_q;
  logic signed [SW-1:0] s1_val_q, s1_d, acc_ext, rnd;
  logic [CNT_W-1:0]    s1_idx_q;
  logic                s1_last_q;

  // S2 stage: saturated byte and its lane
  logic                s2_v_q;
  logic [7:0]          s2_byte_q;
  logic [1:0]          s2_lane_q;
  logic                s2_last_q;
  logic signed [7:0]   q_d;

  // S3 stage: word assembly and write-out
  logic [31:0]         word_q, word_d;
  logic                flush_q, flush_d;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic [CNT_W-1:0]    max_idx_q;
  logic signed [7:0]   max_val_q;

  assign start_ok = (state_q == ST_IDLE) && start;
  // Accept only while the layer still expects neurons; extra pulses are flagged below
  assign accept   = (state_q == ST_RUN) && acc_valid && (cnt_q < num_q);
  assign last_d   = (cnt_q == num_q - 1'b1);

  // Next-state and control-counter logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    overrun_d = overrun_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (cnt_q == num_q) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_v_q && !s2_v_q && !flush_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (start_ok) begin
      cnt_d     = '0;
      waddr_d   = base_addr;
      overrun_d = 1'b0;
    end else begin
      if (accept) cnt_d = cnt_q + 1'b1;
      if (flush_q) waddr_d = waddr_q + 1'b1;
      if (acc_valid && !accept && (state_q == ST_RUN || state_q == ST_DRAIN)) overrun_d = 1'b1;
    end
  end

  // FSM state, layer configuration, counters and sticky overrun flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      cnt_q     <= '0;
      waddr_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      waddr_q   <= waddr_d;
      overrun_q <= overrun_d;
      if (start_ok) begin
        num_q   <= num_neurons;
        shift_q <= shift;
        relu_q  <= relu_en;
      end
    end
  end

  // Round half up then arithmetic shift, one bit wider so the rounding add cannot overflow
  always_comb begin
    acc_ext = {acc_in[ACC_W-1], acc_in};
    rnd     = '0;
    if (shift_q != 5'd0) rnd = SW'(1) << (shift_q - 5'd1);
    s1_d    = (acc_ext + rnd) >>> shift_q;
  end

  // S1 register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q    <= 1'b0;
      s1_val_q  <= '0;
      s1_idx_q  <= '0;
      s1_last_q <= 1'b0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_val_q  <= s1_d;
        s1_idx_q  <= cnt_q;
        s1_last_q <= last_d;
      end
    end
  end

  // Optional ReLU followed by int8 saturation
  always_comb begin
    q_d = s1_val_q[7:0];
    if (relu_q && s1_val_q[SW-1]) q_d = '0;
    else if (s1_val_q > Q_MAX)    q_d = 8'sd127;
    else if (s1_val_q < Q_MIN)    q_d = -8'sd128;
  end

  // S2 register and running argmax (strict compare so ties keep the lower index)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_v_q    <= 1'b0;
      s2_byte_q <= '0;
      s2_lane_q <= '0;
      s2_last_q <= 1'b0;
      max_idx_q <= '0;
      max_val_q <= -8'sd128;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_byte_q <= q_d;
        s2_lane_q <= s1_idx_q[1:0];
        s2_last_q <= s1_last_q;
      end
      if (start_ok) begin
        max_idx_q <= '0;
        max_val_q <= -8'sd128;
      end else if (s1_v_q && (q_d > max_val_q)) begin
        max_idx_q <= s1_idx_q;
        max_val_q <= q_d;
      end
    end
  end

  // Lane insert; lane 0 starts a fresh word so a trailing partial word has zero upper lanes
  always_comb begin
    word_d  = word_q;
    flush_d = 1'b0;
    if (s2_v_q) begin
      unique case (s2_lane_q)
        2'd0: word_d = {24'h0, s2_byte_q};
        2'd1: word_d[15:8]  = s2_byte_q;
        2'd2: word_d[23:16] = s2_byte_q;
        2'd3: word_d[31:24] = s2_byte_q;
        default: word_d = word_q;
      endcase
      flush_d = (s2_lane_q == 2'd3) || s2_last_q;
    end
  end

  // Word register and registered feature-buffer write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q    <= '0;
      flush_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      word_q  <= start_ok ? 32'h0 : word_d;
      flush_q <= flush_d;
      wr_en_q <= flush_q;
      if (flush_q) begin
        wr_addr_q <= waddr_q;
        wr_data_q <= word_q;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign layer_done  = (state_q == ST_DONE);
  assign max_idx     = max_idx_q;
  assign max_val     = max_val_q;
  assign overrun_err = overrun_q;

endmodule

// File: tb/tb_neuron_requant_pack.sv
// tb/tb_neuron_requant_pack.sv - directed scoreboard bench for neuron_requant_pack
module tb_neuron_requant_pack;
  localparam int ACC_W  = 26;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rstn, start, relu_en, acc_valid;
  logic [CNT_W-1:0]  num_neurons;
  logic [4:0]        shift;
  logic [ADDR_W-1:0] base_addr;
  logic [ACC_W-1:0]  acc_in;
  logic              wr_en, busy, layer_done, overrun_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [CNT_W-1:0]  max_idx;
  logic [7:0]        max_val;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t exp_q[$];
  int  stim[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;

  always #5 clk = ~clk;

  neuron_requant_pack #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .num_neurons(num_neurons), .shift(shift),
    .relu_en(relu_en), .base_addr(base_addr), .acc_in(acc_in), .acc_valid(acc_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .layer_done(layer_done), .max_idx(max_idx), .max_val(max_val), .overrun_err(overrun_err)
  );

  function automatic int quant(input int x, input int sh, input bit relu);
    longint v, d;
    d = longint'(1) << sh;
    v = longint'(x) + ((sh > 0) ? d / 2 : 0);
    if (v >= 0) v = v / d;
    else        v = -((-v + d - 1) / d);
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (layer_done) done_cnt++;
    if (wr_en) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected: got addr=%0h data=%08h, expected no write", wr_addr, wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 3;
        assert (wr_addr === e.addr) else begin
          errors++; $error("FAIL wr_addr: got %0h expected %0h", wr_addr, e.addr);
        end
        assert (wr_data === e.data) else begin
          errors++; $error("FAIL wr_data: got %08h expected %08h", wr_data, e.data);
        end
        assert (cyc === e.cyc) else begin
          errors++; $error("FAIL wr_latency: got cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic run_layer(input string tag, input int n, input int sh, input bit relu,
                           input logic [ADDR_W-1:0] base, input int extra,
                           input int exp_idx, input int exp_val, input bit exp_ovr);
    int mx, mi, q, lane, w, waited, want_idx, want_val;
    logic [31:0] word;
    wr_t e;
    num_neurons = CNT_W'(n);
    shift       = 5'(sh);
    relu_en     = relu;
    base_addr   = base;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    checks++;
    assert (busy === 1'b1 && overrun_err === 1'b0) else begin
      errors++; $error("FAIL %s start_state: got busy=%0b ovr=%0b expected busy=1 ovr=0", tag, busy, overrun_err);
    end
    mx = -128; mi = 0; word = '0; w = 0;
    for (int k = 0; k < n + extra; k++) begin
      acc_valid = 1'b1;
      acc_in    = ACC_W'(stim[k]);
      if (k < n) begin
        q    = quant(stim[k], sh, relu);
        lane = k % 4;
        if (lane == 0) word = '0;
        word[8*lane +: 8] = 8'(q);
        if (q > mx) begin mx = q; mi = k; end
        if (lane == 3 || k == n - 1) begin
          e.addr = base + ADDR_W'(w);
          e.data = word;
          e.cyc  = cyc + 4;
          exp_q.push_back(e);
          w++;
        end
      end
      tick();
    end
    acc_valid = 1'b0;
    waited = 0;
    while (!layer_done && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    assert (layer_done === 1'b1) else begin
      errors++; $error("FAIL %s done_timeout: got layer_done=%0b expected 1", tag, layer_done);
    end
    if (n == 0) begin
      checks++;
      assert (waited === 2) else begin
        errors++; $error("FAIL %s empty_done_latency: got %0d expected 2", tag, waited);
      end
    end
    want_idx = (exp_idx < 0) ? mi : exp_idx;
    want_val = (exp_idx < 0) ? mx : exp_val;
    checks += 4;
    assert (exp_q.size() === 0) else begin
      errors++; $error("FAIL %s missing_writes: got %0d pending expected 0", tag, exp_q.size());
    end
    assert (max_idx === CNT_W'(want_idx)) else begin
      errors++; $error("FAIL %s max_idx: got %0d expected %0d", tag, max_idx, want_idx);
    end
    assert (max_val === 8'(want_val)) else begin
      errors++; $error("FAIL %s max_val: got %02h expected %02h", tag, max_val, 8'(want_val));
    end
    assert (overrun_err === exp_ovr) else begin
      errors++; $error("FAIL %s overrun: got %0b expected %0b", tag, overrun_err, exp_ovr);
    end
    tick();
    checks++;
    assert (layer_done === 1'b0 && busy === 1'b0) else begin
      errors++; $error("FAIL %s done_pulse: got done=%0b busy=%0b expected 0 0", tag, layer_done, busy);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert ({wr_en, wr_addr, wr_data, busy, layer_done, max_idx, max_val, overrun_err} ===
            {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 10'h0, 8'h80, 1'b0}) else begin
      errors++;
      $error("FAIL %s reset_outputs: got we=%0b a=%0h d=%08h busy=%0b done=%0b idx=%0d val=%02h ovr=%0b expected all 0, val=80",
             tag, wr_en, wr_addr, wr_data, busy, layer_done, max_idx, max_val, overrun_err);
    end
  endtask

  initial begin
    int d0;
    rstn = 1'b0; start = 1'b0; relu_en = 1'b0; acc_valid = 1'b0;
    num_neurons = '0; shift = '0; base_addr = '0; acc_in = '0;
    repeat (3) tick();
    check_reset("por");
    rstn = 1'b1;
    tick();

    stim = '{160, -50, 4000, 23};
    run_layer("T1", 4, 4, 1'b1, 8'h10, 0, 2, 127, 1'b0);

    stim = '{1, 2, 3, 4, -300};
    run_layer("T2", 5, 0, 1'b0, 8'h20, 0, 3, 4, 1'b0);

    stim = '{-1, -3};
    run_layer("T3", 2, 1, 1'b0, 8'h30, 0, 0, 0, 1'b0);

    stim = '{-33554432, 33554431};
    run_layer("shift25", 2, 25, 1'b0, 8'h40, 0, 1, 1, 1'b0);

    stim = '{10, 20, 30};
    run_layer("T4", 2, 0, 1'b0, 8'h50, 1, 1, 20, 1'b1);

    acc_valid = 1'b1;
    acc_in    = ACC_W'(99);
    repeat (3) tick();
    acc_valid = 1'b0;
    checks++;
    assert (busy === 1'b0 && overrun_err === 1'b1 && max_idx === 10'd1) else begin
      errors++; $error("FAIL idle_acc: got busy=%0b ovr=%0b idx=%0d expected 0 1 1", busy, overrun_err, max_idx);
    end

    stim = '{7, 7, 7};
    run_layer("T5tie", 3, 0, 1'b0, 8'h60, 0, 0, 7, 1'b0);

    stim.delete();
    run_layer("T5empty", 0, 3, 1'b1, 8'h70, 0, 0, -128, 1'b0);

    stim.delete();
    for (int k = 0; k < 9; k++) stim.push_back(int'($urandom_range(4000)) - 2000);
    run_layer("wrap", 9, 3, 1'b1, 8'hFF, 0, -1, 0, 1'b0);

    stim = '{160, -50, 4000, 23};
    num_neurons = 10'd4; shift = 5'd4; relu_en = 1'b1; base_addr = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      acc_valid = 1'b1;
      acc_in    = ACC_W'(stim[k]);
      tick();
    end
    acc_valid = 1'b0;
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    check_reset("T6");
    exp_q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (8) tick();
    checks++;
    assert (done_cnt === d0 && busy === 1'b0) else begin
      errors++; $error("FAIL T6 abort: got done pulses=%0d busy=%0b expected 0 0", done_cnt - d0, busy);
    end

    run_layer("T6rerun", 4, 4, 1'b1, 8'h10, 0, 2, 127, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
